// File: rtl/imm_ext_if.sv
// Handshake bundle for imm_ext_pipe: producer side (in_*), consumer side (out_*), and flush.
interface imm_ext_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             flush;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready, flush,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready, flush,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate extender feeding a 2-entry elastic buffer at the ID->EX boundary.
// Define IMM_EXT_BRANCH_EN to make mode 11 a branch offset (sign-extend, <<2); otherwise it is plain sign-extend.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    imm_ext_if.slave  bus
);
    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0]          zext, sext, ext_data;
    logic [1:0][OUT_W-1:0]     data_q, data_d;
    logic [1:0][TAG_W-1:0]     tag_q, tag_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic                      push, pop;

    assign zext = {{PAD_W{1'b0}}, bus.in_imm};
    assign sext = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};

    always_comb begin
        ext_data = zext;
        case (bus.in_mode)
            2'b00: ext_data = zext;
            2'b01: ext_data = sext;
            2'b10: ext_data = zext << IN_W;
`ifdef IMM_EXT_BRANCH_EN
            2'b11: ext_data = sext << 2;
`else
            2'b11: ext_data = sext;
`endif
            default: ext_data = zext;
        endcase
    end

    // Ready depends only on the registered count, so there is no path from out_ready to in_ready.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_tag   = tag_q[rd_ptr_q];

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            // Storage is left stale; only the bookkeeping is cleared.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = ext_data;
                tag_d[wr_ptr_q]  = bus.in_tag;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            tag_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            data_q   <= data_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: queue model of the 2-deep FIFO plus arithmetic extension model, with directed vectors.
module tb_imm_ext_pipe;
    logic clk;
    logic rst;

    imm_ext_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
    imm_ext_if #(.IN_W(12), .OUT_W(20), .TAG_W(5)) bus2 ();

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(5)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } ent_t;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   started = 0;

    // Extension from the arithmetic meaning of each mode, reduced modulo 2**ow.
    function automatic logic [63:0] ext_model(int iw, int ow, logic [63:0] imm, int mode);
        longint s, r;
        logic [63:0] mask;
        mask = (64'd1 << ow) - 64'd1;
        if (imm >= (64'd1 << (iw - 1))) s = longint'(imm) - (longint'(1) << iw);
        else                            s = longint'(imm);
        case (mode)
            0: r = longint'(imm);
            1: r = s;
            2: r = longint'(imm) * (longint'(1) << iw);
`ifdef IMM_EXT_BRANCH_EN
            default: r = s * 4;
`else
            default: r = s;
`endif
        endcase
        return 64'(r) & mask;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one edge and move the model by the same handshake rules.
    task automatic cycle();
        bit   pu, po;
        ent_t e;
        @(posedge clk);
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            pu = bus.in_valid && (q.size() < 2);
            po = bus.out_ready && (q.size() > 0);
            if (po) void'(q.pop_front());
            if (pu) begin
                e.d = 32'(ext_model(16, 32, 64'(bus.in_imm), int'(bus.in_mode)));
                e.t = bus.in_tag;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drive(logic v, logic [15:0] imm, logic [1:0] mode, logic [4:0] tag);
        bus.in_valid = v;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
        bus.in_tag   = tag;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
                chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
                if (q.size() != 0) begin
                    chk("out_data", 64'(bus.out_data), 64'(q[0].d));
                    chk("out_tag", 64'(bus.out_tag), 64'(q[0].t));
                end
            end
        end
    end

    logic [31:0] mode_lit [4];
    int          stream_valid;

    initial begin
        mode_lit[0] = 32'h0000_8001;
        mode_lit[1] = 32'hFFFF_8001;
        mode_lit[2] = 32'h8001_0000;
`ifdef IMM_EXT_BRANCH_EN
        mode_lit[3] = 32'hFFFE_0004;
`else
        mode_lit[3] = 32'hFFFF_8001;
`endif
        rst = 1'b1;
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        bus.out_ready  = 1'b0;
        bus.flush      = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_imm    = '0;
        bus2.in_mode   = 2'd0;
        bus2.in_tag    = '0;
        bus2.out_ready = 1'b0;
        bus2.flush     = 1'b0;
        cycle();
        cycle();
        started = 1;
        rst = 1'b0;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_data", 64'(bus.out_data), 64'd0);
        chk("reset_out_tag", 64'(bus.out_tag), 64'd0);

        // Each mode on 16'h8001 with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 16'h8001, 2'(m), 5'(m + 1));
            cycle();
            chk($sformatf("mode%0d_data", m), 64'(bus.out_data), 64'(mode_lit[m]));
            chk($sformatf("mode%0d_tag", m), 64'(bus.out_tag), 64'(m + 1));
        end
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        cycle();

        // Back-pressure: third entry must be held at the input.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0001, 2'd0, 5'd1);
        cycle();
        chk("bp_ready_after_1", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 16'h0002, 2'd0, 5'd2);
        cycle();
        chk("bp_ready_after_2", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 16'h0003, 2'd0, 5'd3);
        cycle();
        chk("bp_still_full", 64'(bus.in_ready), 64'd0);
        chk("bp_head_tag1", 64'(bus.out_tag), 64'd1);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_out_tag2", 64'(bus.out_tag), 64'd2);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        cycle();
        chk("bp_out_tag3", 64'(bus.out_tag), 64'd3);
        chk("bp_out_data3", 64'(bus.out_data), 64'h3);
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        cycle();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Streaming: one output per cycle, one cycle behind its input.
        stream_valid = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), 2'(i % 4), 5'(8 + i));
            cycle();
            chk("stream_tag", 64'(bus.out_tag), 64'(8 + i));
            if (bus.out_valid && bus.in_ready) stream_valid++;
        end
        chk("stream_count", 64'(stream_valid), 64'd8);
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        cycle();

        // Flush with a full buffer and a same-cycle input.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 2'd1, 5'd20);
        cycle();
        drive(1'b1, 16'h5555, 2'd2, 5'd21);
        cycle();
        chk("flush_pre_full", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 16'h7777, 2'd0, 5'd22);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        chk("flush_input_dropped", 64'(bus.out_valid), 64'd0);

        // Synchronous reset while full; deassertion mid-cycle.
        drive(1'b1, 16'h1234, 2'd2, 5'd30);
        cycle();
        drive(1'b1, 16'h4321, 2'd1, 5'd31);
        cycle();
        drive(1'b0, 16'h0, 2'd0, 5'd0);
        rst = 1'b1;
        #2;
        chk("rst_not_yet", 64'(bus.out_valid), 64'd1);
        cycle();
        #3;
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        cycle();
        chk("rst_stays_empty", 64'(bus.out_valid), 64'd0);

        // Narrow instance: IN_W=12, OUT_W=20.
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.in_imm    = 12'h800;
        bus2.in_mode   = 2'd1;
        bus2.in_tag    = 5'd4;
        cycle();
        chk("w12_sign", 64'(bus2.out_data), 64'h0_FF800);
        chk("w12_valid", 64'(bus2.out_valid), 64'd1);
        bus2.in_imm  = 12'h123;
        bus2.in_mode = 2'd2;
        cycle();
        chk("w12_upper", 64'(bus2.out_data), 64'h0_23000);
        bus2.in_imm  = 12'hFFF;
        bus2.in_mode = 2'd3;
        cycle();
        chk("w12_mode3", 64'(bus2.out_data), ext_model(12, 20, 64'hFFF, 3));
        bus2.in_valid = 1'b0;
        cycle();
        chk("w12_drained", 64'(bus2.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate extender for the ID→EX boundary. Accepts a raw instruction immediate with a mode select and a passthrough tag, then produces the registered OUT_W-bit operand. The supported modes are zero-extend, sign-extend, upper-load shift and branch-offset. A 2-entry elastic buffer with valid/ready handshakes on both sides absorbs one cycle of EX back-pressure without a combinational ready path. A flush input drops all in-flight entries on branch mispredict or exception.

## Interface
Parameters:
- IN_W, 16, raw immediate width.
- OUT_W, 32, extended operand width; must satisfy OUT_W ≥ IN_W+2.
- TAG_W, 5, width of the sideband tag carried with each entry (e.g. destination register).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  producer has an immediate.
- in_ready  out  1  buffer can accept; registered, equals (count != 2).
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  00 zero, 01 sign, 10 upper, 11 branch.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  OUT_W  extended operand of head entry.
- out_tag  out  TAG_W  tag of head entry.
- flush  in  1  discard all entries and any same-cycle input.

## Operation
- Extension is computed combinationally at input and stored already extended. Entries hold {data, tag}.
- Mode 00: {zeros, imm}.
- Mode 01: imm[IN_W-1] replicated to OUT_W.
- Mode 10: zero-extended imm shifted left by IN_W, truncated to OUT_W. With defaults this is {imm, 16'h0}.
- Mode 11: sign-extended imm shifted left by 2, truncated to OUT_W. For example, 16'hFFFF gives 32'hFFFF_FFFC.
- Push occurs on in_valid && in_ready. Pop occurs on out_valid && out_ready.
- Storage is a 2-entry circular buffer with wr_ptr, rd_ptr (1 bit each) and count (0..2).
- Simultaneous push and pop is allowed whenever in_ready=1: count is unchanged and both pointers advance.
- When count=2, in_ready=0 even if a pop occurs that cycle. No combinational ready path exists.
- Pop while empty is ignored (out_ready with out_valid=0).
- Push while full cannot occur. If in_valid is asserted while full, the input is not accepted and the producer must hold it.
- flush has priority over push and pop. On the next edge, count=0, both pointers return to 0, and out_valid=0. Stale storage contents are not cleared.
- rst has priority over flush.
- If rst is asserted mid-transfer, the entry is lost. No partial state persists.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_tag=0, count=0, wr_ptr=0, rd_ptr=0.
- Latency: input accepted at edge N is visible on out_data/out_valid after edge N when the buffer was empty. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure: with out_ready held low, the second accepted entry drives in_ready low after that edge. In_ready returns high one edge after the first pop.
- out_data and out_tag are stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO.

## Configuration
- Macro: IMM_EXT_BRANCH_EN.
- Defined: mode 11 performs the branch-offset extension (sign-extend, <<2).
- Undefined: mode 11 behaves exactly as mode 01 (plain sign-extend), and the shift logic is not synthesised.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then drive in_imm=16'h8001 in each mode with out_ready=1. Required outputs:
  - Mode 00 → 32'h0000_8001.
  - Mode 01 → 32'hFFFF_8001.
  - Mode 10 → 32'h8001_0000.
  - Mode 11 → 32'hFFFE_0004 with IMM_EXT_BRANCH_EN, 32'hFFFF_8001 without it.
- Back-pressure: hold out_ready=0 and push tags 1, 2, 3. Required: in_ready=0 after the 2nd accept and tag 3 held at input. Release out_ready: tags 1, 2, 3 emerge in order, one per cycle.
- Streaming: with in_valid=1 and out_ready=1 for 8 cycles, 8 outputs emerge on consecutive cycles, each 1 cycle after its input, count staying at 1.
- Flush with 2 entries plus in_valid=1: next cycle out_valid=0, in_ready=1, count=0, and the same-cycle input is dropped.
- Synchronous reset asserted while full and out_ready=0: after the edge all outputs are at reset values. Reset deasserted mid-cycle has no effect until the next edge.
- Width sweep with IN_W=12, OUT_W=20: mode 01 with 12'h800 → 20'hFF800; mode 10 with 12'h123 → 20'h23000 (truncated).
